// File: rtl/wb_queue_if.sv
// Bus bundle for wb_queue: load/ALU result channels plus register-file write port.
// Bypass lookup signals exist only when WB_QUEUE_BYPASS_EN is defined.
interface wb_queue_if #(
    parameter int unsigned WordSize = 32,
    parameter int unsigned Depth    = 4
);
    logic                      ld_valid;
    logic                      ld_ready;
    logic [4:0]                ld_rdn;
    logic [WordSize-1:0]       ld_rdd;
    logic                      alu_valid;
    logic                      alu_ready;
    logic [4:0]                alu_rdn;
    logic [WordSize-1:0]       alu_rdd;
    logic                      wb_stall;
    logic                      wbe;
    logic [4:0]                rdn;
    logic [WordSize-1:0]       rdd;
    logic [$clog2(Depth):0]    count;
`ifdef WB_QUEUE_BYPASS_EN
    logic [4:0]                rs1n;
    logic [4:0]                rs2n;
    logic                      rs1_hit;
    logic                      rs2_hit;
    logic [WordSize-1:0]       rs1_fwd;
    logic [WordSize-1:0]       rs2_fwd;

    modport slave (
        input  ld_valid, ld_rdn, ld_rdd, alu_valid, alu_rdn, alu_rdd, wb_stall, rs1n, rs2n,
        output ld_ready, alu_ready, wbe, rdn, rdd, count, rs1_hit, rs2_hit, rs1_fwd, rs2_fwd
    );
    modport master (
        output ld_valid, ld_rdn, ld_rdd, alu_valid, alu_rdn, alu_rdd, wb_stall, rs1n, rs2n,
        input  ld_ready, alu_ready, wbe, rdn, rdd, count, rs1_hit, rs2_hit, rs1_fwd, rs2_fwd
    );
`else
    modport slave (
        input  ld_valid, ld_rdn, ld_rdd, alu_valid, alu_rdn, alu_rdd, wb_stall,
        output ld_ready, alu_ready, wbe, rdn, rdd, count
    );
    modport master (
        output ld_valid, ld_rdn, ld_rdd, alu_valid, alu_rdn, alu_rdd, wb_stall,
        input  ld_ready, alu_ready, wbe, rdn, rdd, count
    );
`endif
endinterface

// File: rtl/wb_queue.sv
// Write-back FIFO merging load and ALU results onto one register-file write port.
// Define WB_QUEUE_BYPASS_EN to add rs1/rs2 forwarding lookup over queued entries.
module wb_queue #(
    parameter int unsigned WordSize = 32,
    parameter int unsigned Depth    = 4
) (
    input  logic      clk,
    input  logic      rst,
    wb_queue_if.slave bus
);
    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;
    typedef logic [PtrW-1:0] ptr_t;
    typedef logic [CntW-1:0] cnt_t;

    logic [4:0]          rdn_mem [Depth];
    logic [WordSize-1:0] rdd_mem [Depth];

    ptr_t wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, alu_slot;
    cnt_t count_q, count_d, free;
    logic ld_ready, alu_ready, ld_push, alu_push, pop, occupied;

    always_comb begin
        free      = cnt_t'(Depth) - count_q;
        occupied  = (count_q != '0);
        // Readies come from registered occupancy only, never from this cycle's pop.
        ld_ready  = (free != '0);
        alu_ready = (free >= cnt_t'(2)) || ((free == cnt_t'(1)) && !bus.ld_valid);
        ld_push   = bus.ld_valid && ld_ready && (bus.ld_rdn != 5'd0);
        alu_push  = bus.alu_valid && alu_ready && (bus.alu_rdn != 5'd0);
        pop       = occupied && !bus.wb_stall;
        alu_slot  = wr_ptr_q + ptr_t'(ld_push);
        wr_ptr_d  = alu_slot + ptr_t'(alu_push);
        rd_ptr_d  = rd_ptr_q + ptr_t'(pop);
        count_d   = count_q + cnt_t'(ld_push) + cnt_t'(alu_push) - cnt_t'(pop);
    end

    always_comb begin
        bus.ld_ready  = ld_ready;
        bus.alu_ready = alu_ready;
        bus.wbe       = pop;
        bus.rdn       = occupied ? rdn_mem[rd_ptr_q] : 5'd0;
        bus.rdd       = occupied ? rdd_mem[rd_ptr_q] : '0;
        bus.count     = count_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is unreset; stale contents are masked by count.
    always_ff @(posedge clk) begin
        if (ld_push) begin
            rdn_mem[wr_ptr_q] <= bus.ld_rdn;
            rdd_mem[wr_ptr_q] <= bus.ld_rdd;
        end
        if (alu_push) begin
            rdn_mem[alu_slot] <= bus.alu_rdn;
            rdd_mem[alu_slot] <= bus.alu_rdd;
        end
    end

`ifdef WB_QUEUE_BYPASS_EN
    ptr_t byp_idx;

    // Walk oldest to youngest so the last match wins.
    always_comb begin
        byp_idx     = '0;
        bus.rs1_hit = 1'b0;
        bus.rs2_hit = 1'b0;
        bus.rs1_fwd = '0;
        bus.rs2_fwd = '0;
        for (int unsigned i = 0; i < Depth; i++) begin
            if (cnt_t'(i) < count_q) begin
                byp_idx = rd_ptr_q + ptr_t'(i);
                if ((bus.rs1n != 5'd0) && (rdn_mem[byp_idx] == bus.rs1n)) begin
                    bus.rs1_hit = 1'b1;
                    bus.rs1_fwd = rdd_mem[byp_idx];
                end
                if ((bus.rs2n != 5'd0) && (rdn_mem[byp_idx] == bus.rs2n)) begin
                    bus.rs2_hit = 1'b1;
                    bus.rs2_fwd = rdd_mem[byp_idx];
                end
            end
        end
    end
`endif
endmodule

// File: tb/tb_wb_queue.sv
// Self-checking bench for wb_queue: directed scenarios plus random traffic against a queue model.
module tb_wb_queue;
    localparam int unsigned WordSize = 32;
    localparam int unsigned Depth    = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_queue_if #(.WordSize(WordSize), .Depth(Depth)) bus ();

    wb_queue #(.WordSize(WordSize), .Depth(Depth)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [36:0] mq[$];  // {rdn, rdd}, head at index 0

    function automatic int free_slots();
        return int'(Depth) - mq.size();
    endfunction
    function automatic logic exp_ld_ready();
        return free_slots() >= 1;
    endfunction
    function automatic logic exp_alu_ready();
        return (free_slots() >= 2) || (free_slots() == 1 && !bus.ld_valid);
    endfunction
    function automatic logic exp_wbe();
        return (mq.size() != 0) && !bus.wb_stall;
    endfunction
    function automatic logic [4:0] exp_rdn();
        return (mq.size() != 0) ? mq[0][36:32] : 5'd0;
    endfunction
    function automatic logic [31:0] exp_rdd();
        return (mq.size() != 0) ? mq[0][31:0] : 32'd0;
    endfunction
    function automatic logic [2:0] exp_count();
        return 3'(mq.size());
    endfunction
`ifdef WB_QUEUE_BYPASS_EN
    function automatic logic [32:0] exp_byp(input logic [4:0] rsn);
        if (rsn == 5'd0) return 33'd0;
        for (int i = mq.size() - 1; i >= 0; i--)
            if (mq[i][36:32] == rsn) return {1'b1, mq[i][31:0]};
        return 33'd0;
    endfunction
`endif

    task automatic idle();
        bus.ld_valid  = 1'b0;
        bus.ld_rdn    = 5'd0;
        bus.ld_rdd    = '0;
        bus.alu_valid = 1'b0;
        bus.alu_rdn   = 5'd0;
        bus.alu_rdd   = '0;
        bus.wb_stall  = 1'b0;
`ifdef WB_QUEUE_BYPASS_EN
        bus.rs1n = 5'd0;
        bus.rs2n = 5'd0;
`endif
    endtask

    // Advance the model by the current inputs, then move to the next negedge.
    task automatic tick();
        logic ldr, alur, pp;
        ldr  = exp_ld_ready();
        alur = exp_alu_ready();
        pp   = exp_wbe();
        if (pp) void'(mq.pop_front());
        if (bus.ld_valid && ldr && bus.ld_rdn != 5'd0) mq.push_back({bus.ld_rdn, bus.ld_rdd});
        if (bus.alu_valid && alur && bus.alu_rdn != 5'd0) mq.push_back({bus.alu_rdn, bus.alu_rdd});
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        mq.delete();
        #1;
        for (int k = 0; k < 2; k++) begin
            n_checks += 6;
            if (bus.count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", bus.count); end
            if (bus.wbe !== 1'b0) begin n_fail++; $display("FAIL reset_wbe got %b want 0", bus.wbe); end
            if (bus.rdn !== 5'd0) begin n_fail++; $display("FAIL reset_rdn got %0d want 0", bus.rdn); end
            if (bus.rdd !== 32'd0) begin n_fail++; $display("FAIL reset_rdd got %h want 0", bus.rdd); end
            if (bus.ld_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ld_ready got %b want 1", bus.ld_ready); end
            if (bus.alu_ready !== 1'b1) begin n_fail++; $display("FAIL reset_alu_ready got %b want 1", bus.alu_ready); end
            @(negedge clk);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_load();
        bus.ld_valid = 1'b1; bus.ld_rdn = 5'd5; bus.ld_rdd = 32'hAAAA0005;
        #1;
        n_checks++;
        if (bus.ld_ready !== 1'b1) begin n_fail++; $display("FAIL single_ld_ready got %b want 1", bus.ld_ready); end
        tick();
        idle();
        #1;
        n_checks += 3;
        if (bus.wbe !== 1'b1) begin n_fail++; $display("FAIL single_wbe got %b want 1", bus.wbe); end
        if (bus.rdn !== 5'd5) begin n_fail++; $display("FAIL single_rdn got %0d want 5", bus.rdn); end
        if (bus.rdd !== 32'hAAAA0005) begin n_fail++; $display("FAIL single_rdd got %h want aaaa0005", bus.rdd); end
        tick();
        #1;
        n_checks += 2;
        if (bus.wbe !== 1'b0) begin n_fail++; $display("FAIL single_wbe_after got %b want 0", bus.wbe); end
        if (bus.count !== 3'd0) begin n_fail++; $display("FAIL single_count_after got %0d want 0", bus.count); end
    endtask

    task automatic test_dual_push();
        bus.ld_valid = 1'b1; bus.ld_rdn = 5'd3; bus.ld_rdd = 32'h0000_0333;
        bus.alu_valid = 1'b1; bus.alu_rdn = 5'd4; bus.alu_rdd = 32'h0000_0444;
        #1;
        n_checks += 2;
        if (bus.ld_ready !== 1'b1) begin n_fail++; $display("FAIL dual_ld_ready got %b want 1", bus.ld_ready); end
        if (bus.alu_ready !== 1'b1) begin n_fail++; $display("FAIL dual_alu_ready got %b want 1", bus.alu_ready); end
        tick();
        idle();
        for (int k = 0; k < 2; k++) begin
            #1;
            n_checks += 3;
            if (bus.wbe !== 1'b1) begin n_fail++; $display("FAIL dual_wbe[%0d] got %b want 1", k, bus.wbe); end
            if (bus.rdn !== 5'(3 + k)) begin n_fail++; $display("FAIL dual_rdn[%0d] got %0d want %0d", k, bus.rdn, 3 + k); end
            if (bus.count !== 3'(2 - k)) begin n_fail++; $display("FAIL dual_count[%0d] got %0d want %0d", k, bus.count, 2 - k); end
            tick();
        end
    endtask

    task automatic test_zero_rdn();
        bus.alu_valid = 1'b1; bus.alu_rdn = 5'd0; bus.alu_rdd = 32'hDEAD_BEEF;
        #1;
        n_checks++;
        if (bus.alu_ready !== 1'b1) begin n_fail++; $display("FAIL zero_alu_ready got %b want 1", bus.alu_ready); end
        tick();
        idle();
        #1;
        n_checks += 2;
        if (bus.count !== 3'd0) begin n_fail++; $display("FAIL zero_count got %0d want 0", bus.count); end
        if (bus.wbe !== 1'b0) begin n_fail++; $display("FAIL zero_wbe got %b want 0", bus.wbe); end
    endtask

    task automatic test_stall_fill();
        logic [31:0] data [4];
        bus.wb_stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            data[k] = $urandom;
            bus.alu_valid = 1'b1; bus.alu_rdn = 5'(10 + k); bus.alu_rdd = data[k];
            tick();
        end
        bus.alu_valid = 1'b0;
        #1;
        n_checks += 4;
        if (bus.count !== 3'd4) begin n_fail++; $display("FAIL stall_count got %0d want 4", bus.count); end
        if (bus.ld_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ld_ready got %b want 0", bus.ld_ready); end
        if (bus.alu_ready !== 1'b0) begin n_fail++; $display("FAIL stall_alu_ready got %b want 0", bus.alu_ready); end
        if (bus.wbe !== 1'b0) begin n_fail++; $display("FAIL stall_wbe got %b want 0", bus.wbe); end
        bus.wb_stall = 1'b0;
        bus.ld_valid = 1'b1; bus.ld_rdn = 5'd9; bus.alu_valid = 1'b1; bus.alu_rdn = 5'd9;
        #1;
        // Full and popping: readies must still be low.
        n_checks += 2;
        if (bus.ld_ready !== 1'b0) begin n_fail++; $display("FAIL fullpop_ld_ready got %b want 0", bus.ld_ready); end
        if (bus.alu_ready !== 1'b0) begin n_fail++; $display("FAIL fullpop_alu_ready got %b want 0", bus.alu_ready); end
        for (int k = 0; k < 4; k++) begin
            if (k == 1) idle();
            #1;
            n_checks += 3;
            if (bus.wbe !== 1'b1) begin n_fail++; $display("FAIL drain_wbe[%0d] got %b want 1", k, bus.wbe); end
            if (bus.rdn !== 5'(10 + k)) begin n_fail++; $display("FAIL drain_rdn[%0d] got %0d want %0d", k, bus.rdn, 10 + k); end
            if (bus.rdd !== data[k]) begin n_fail++; $display("FAIL drain_rdd[%0d] got %h want %h", k, bus.rdd, data[k]); end
            tick();
        end
        #1;
        n_checks++;
        if (bus.count !== 3'd0) begin n_fail++; $display("FAIL drain_count got %0d want 0", bus.count); end
    endtask

    task automatic test_partial_and_async_reset();
        bus.wb_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.alu_valid = 1'b1; bus.alu_rdn = 5'(1 + k); bus.alu_rdd = 32'(100 + k);
            tick();
        end
        bus.ld_valid = 1'b1; bus.ld_rdn = 5'd20; bus.ld_rdd = 32'h2020;
        bus.alu_valid = 1'b1; bus.alu_rdn = 5'd21; bus.alu_rdd = 32'h2121;
        #1;
        n_checks += 3;
        if (bus.count !== 3'd3) begin n_fail++; $display("FAIL part_count got %0d want 3", bus.count); end
        if (bus.ld_ready !== 1'b1) begin n_fail++; $display("FAIL part_ld_ready got %b want 1", bus.ld_ready); end
        if (bus.alu_ready !== 1'b0) begin n_fail++; $display("FAIL part_alu_ready got %b want 0", bus.alu_ready); end
        tick();
        idle();
        #1;
        n_checks += 2;
        if (bus.count !== 3'd4) begin n_fail++; $display("FAIL part_count_after got %0d want 4", bus.count); end
        if (bus.wbe !== 1'b1) begin n_fail++; $display("FAIL part_wbe got %b want 1", bus.wbe); end
        #1 rst = 1'b1;
        mq.delete();
        #1;
        n_checks += 4;
        if (bus.count !== 3'd0) begin n_fail++; $display("FAIL async_count got %0d want 0", bus.count); end
        if (bus.wbe !== 1'b0) begin n_fail++; $display("FAIL async_wbe got %b want 0", bus.wbe); end
        if (bus.rdn !== 5'd0) begin n_fail++; $display("FAIL async_rdn got %0d want 0", bus.rdn); end
        if (bus.ld_ready !== 1'b1) begin n_fail++; $display("FAIL async_ld_ready got %b want 1", bus.ld_ready); end
        #1 rst = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if (bus.count !== 3'd0) begin n_fail++; $display("FAIL post_reset_count got %0d want 0", bus.count); end
    endtask

`ifdef WB_QUEUE_BYPASS_EN
    task automatic test_bypass();
        bus.wb_stall = 1'b1;
        bus.alu_valid = 1'b1; bus.alu_rdn = 5'd7; bus.alu_rdd = 32'd1;
        tick();
        bus.alu_rdd = 32'd2;
        tick();
        bus.alu_valid = 1'b0;
        bus.rs1n = 5'd7; bus.rs2n = 5'd0;
        #1;
        n_checks += 4;
        if (bus.rs1_hit !== 1'b1) begin n_fail++; $display("FAIL byp_rs1_hit got %b want 1", bus.rs1_hit); end
        if (bus.rs1_fwd !== 32'd2) begin n_fail++; $display("FAIL byp_rs1_fwd got %0d want 2", bus.rs1_fwd); end
        if (bus.rs2_hit !== 1'b0) begin n_fail++; $display("FAIL byp_rs2_hit got %b want 0", bus.rs2_hit); end
        if (bus.rs2_fwd !== 32'd0) begin n_fail++; $display("FAIL byp_rs2_fwd got %0d want 0", bus.rs2_fwd); end
        idle();
        for (int k = 0; k < 4 && mq.size() != 0; k++) tick();
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            bus.ld_valid  = ($urandom_range(0, 99) < 50);
            bus.ld_rdn    = 5'($urandom_range(0, 7));
            bus.ld_rdd    = $urandom;
            bus.alu_valid = ($urandom_range(0, 99) < 50);
            bus.alu_rdn   = 5'($urandom_range(0, 7));
            bus.alu_rdd   = $urandom;
            bus.wb_stall  = ($urandom_range(0, 99) < 35);
`ifdef WB_QUEUE_BYPASS_EN
            bus.rs1n = 5'($urandom_range(0, 7));
            bus.rs2n = 5'($urandom_range(0, 7));
`endif
            #1;
            n_checks += 6;
            if (bus.ld_ready !== exp_ld_ready()) begin n_fail++; $display("FAIL rnd_ld_ready c%0d got %b want %b", c, bus.ld_ready, exp_ld_ready()); end
            if (bus.alu_ready !== exp_alu_ready()) begin n_fail++; $display("FAIL rnd_alu_ready c%0d got %b want %b", c, bus.alu_ready, exp_alu_ready()); end
            if (bus.wbe !== exp_wbe()) begin n_fail++; $display("FAIL rnd_wbe c%0d got %b want %b", c, bus.wbe, exp_wbe()); end
            if (bus.rdn !== exp_rdn()) begin n_fail++; $display("FAIL rnd_rdn c%0d got %0d want %0d", c, bus.rdn, exp_rdn()); end
            if (bus.rdd !== exp_rdd()) begin n_fail++; $display("FAIL rnd_rdd c%0d got %h want %h", c, bus.rdd, exp_rdd()); end
            if (bus.count !== exp_count()) begin n_fail++; $display("FAIL rnd_count c%0d got %0d want %0d", c, bus.count, exp_count()); end
`ifdef WB_QUEUE_BYPASS_EN
            n_checks += 2;
            if ({bus.rs1_hit, bus.rs1_fwd} !== exp_byp(bus.rs1n)) begin
                n_fail++; $display("FAIL rnd_rs1 c%0d got %b/%h want %h", c, bus.rs1_hit, bus.rs1_fwd, exp_byp(bus.rs1n));
            end
            if ({bus.rs2_hit, bus.rs2_fwd} !== exp_byp(bus.rs2n)) begin
                n_fail++; $display("FAIL rnd_rs2 c%0d got %b/%h want %h", c, bus.rs2_hit, bus.rs2_fwd, exp_byp(bus.rs2n));
            end
`endif
            tick();
        end
        idle();
        for (int k = 0; k < 8 && mq.size() != 0; k++) tick();
        #1;
        n_checks++;
        if (bus.count !== 3'd0 || mq.size() != 0) begin
            n_fail++; $display("FAIL rnd_drain got %0d want 0 (model %0d)", bus.count, mq.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_dual_push();
        test_zero_rdn();
        test_stall_fill();
        test_partial_and_async_reset();
`ifdef WB_QUEUE_BYPASS_EN
        test_bypass();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_queue.md
WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 The block SHALL take parameter WordSize, default 32, giving the data width of every write-back value.
REQ-002 The block SHALL take parameter Depth, default 4, giving the number of queue entries; legal values are powers of two, minimum 2.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 ld_valid  input  1  load unit presents a result.
REQ-006 ld_ready  output  1  load result accepted this cycle when high together with ld_valid.
REQ-007 ld_rdn  input  5  load destination register.
REQ-008 ld_rdd  input  WordSize  load result data.
REQ-009 alu_valid, alu_ready, alu_rdn, alu_rdd  same directions and widths as the ld_* ports  ALU result channel.
REQ-010 wb_stall  input  1  register-file write port unavailable this cycle.
REQ-011 wbe  output  1  register-file write enable.
REQ-012 rdn  output  5  register-file write address.
REQ-013 rdd  output  WordSize  register-file write data.
REQ-014 count  output  $clog2(Depth)+1  number of occupied entries.

Function
REQ-015 The block SHALL be a FIFO of {rdn, rdd} entries that drives the register-file write port from its head entry.
REQ-016 Handshake: a channel transfer SHALL occur in every cycle where valid and ready are both high at the rising edge.
REQ-017 Ready from registered state: free = Depth - count; ld_ready = (free >= 1); alu_ready = (free >= 2) or (free == 1 and not ld_valid).
REQ-018 Ready SHALL NOT depend on the same-cycle pop; a full queue deasserts both readies even when it is popping.
REQ-019 Two transfers in one cycle SHALL both be enqueued, the load entry ahead of the ALU entry.
REQ-020 A transfer with rdn == 0 SHALL complete the handshake but SHALL NOT be enqueued or written.
REQ-021 wbe SHALL be (count != 0) and not wb_stall; rdn and rdd SHALL show the head entry when count != 0 and 0 otherwise; all three are combinational.
REQ-022 The head entry SHALL be popped at the rising edge of every cycle in which wbe is high, so the write latency is one entry per cycle.
REQ-023 An enqueue into an empty, unstalled queue SHALL appear on wbe in the following cycle.
REQ-024 A simultaneous push and pop SHALL update count by (pushes - 1).
REQ-025 Read and write pointers SHALL wrap modulo Depth.
REQ-026 count SHALL never exceed Depth; overflow is impossible by construction of REQ-017.
REQ-027 While wb_stall is high, entries SHALL accumulate up to Depth with no write and no loss.

Reset
REQ-028 While rst is high, count, both pointers and the outputs wbe, rdn and rdd SHALL be 0, and ld_ready and alu_ready SHALL be 1.
REQ-029 Reset asserted mid-operation SHALL discard all queued entries immediately, without waiting for a clock edge.
REQ-030 Entry storage SHALL need no reset; outputs are gated by count per REQ-021.
REQ-031 The first transfer SHALL be accepted at the first rising edge after rst falls.

Configuration
REQ-032 With macro WB_QUEUE_BYPASS_EN defined, the block SHALL add ports rs1n and rs2n (input, 5 bits), rs1_hit and rs2_hit (output, 1 bit), and rs1_fwd and rs2_fwd (output, WordSize).
REQ-033 With the macro defined, rsX_hit SHALL be high when rsXn != 0 and a queued entry has rdn == rsXn, and rsX_fwd SHALL carry the youngest matching entry's data, or 0 on a miss; both outputs are combinational.
REQ-034 Without the macro, those ports and the lookup logic SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-035 Reset, then ld (rdn=5, rdd=0xAAAA0005) in one cycle -> next cycle wbe=1, rdn=5, rdd=0xAAAA0005; following cycle wbe=0, count=0.
REQ-036 Both channels valid in the same cycle with an empty queue (ld rdn=3, alu rdn=4) -> both accepted; writes of 3 then 4 on consecutive cycles.
REQ-037 wb_stall=1 and 4 ALU pushes -> count=4, ld_ready=0, alu_ready=0; release stall -> four writes in order, one per cycle.
REQ-038 ALU push with rdn=0 -> alu_ready handshake completes, count stays 0, wbe stays 0.
REQ-039 Count at 3 with both channels valid -> only the load is accepted, alu_ready=0; rst pulsed mid-cycle -> count=0 and wbe=0 asynchronously.
REQ-040 With bypass enabled and stall held, push rdn=7 data=1 then rdn=7 data=2 with rs1n=7 -> rs1_hit=1, rs1_fwd=2; with rs2n=0 -> rs2_hit=0.
